// File: rtl/coord_rx_pkg.sv
// Shared types and constants for the coordinate UART receiver.
//   parser_state_e : packet parser states, one per byte position in a packet
//   rx_state_e     : bit-level UART receiver states
//   PKT_LEN        : bytes per coordinate packet (SYNC + 6 payload + CSUM)
//   X_RST/Y_RST/Z_RST : coordinate values presented out of reset
`timescale 1ns/1ps
package coord_rx_pkg;

  localparam int PKT_LEN = 8;

  localparam logic [15:0] X_RST = 16'd0;
  localparam logic [15:0] Y_RST = 16'd1000;
  localparam logic [15:0] Z_RST = 16'd1000;

  // Encoding equals the byte index within the packet, so the parser can
  // advance by incrementing the state.
  typedef enum logic [2:0] {
    S_SYNC = 3'd0,
    S_X_HI = 3'd1,
    S_X_LO = 3'd2,
    S_Y_HI = 3'd3,
    S_Y_LO = 3'd4,
    S_Z_HI = 3'd5,
    S_Z_LO = 3'd6,
    S_CSUM = 3'(PKT_LEN - 1)
  } parser_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,   // waiting for a falling edge
    RX_START,  // confirming the start bit at half a bit
    RX_DATA,   // sampling 8 data bits, LSB first
    RX_STOP,   // sampling the stop bit
    RX_BREAK   // stop bit was low; wait for the line to return high
  } rx_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver.
//   clk, rst_n  : system clock, asynchronous active-low reset
//   rx          : asynchronous serial input, idle high
//   byte_data   : received byte, valid while byte_strobe is high
//   byte_strobe : 1-cycle pulse per byte with a good (high) stop bit
//   stop_err    : 1-cycle pulse when the stop bit is sampled low
// CLKS_PER_BIT sets the bit period in clk cycles.
`timescale 1ns/1ps
module uart_rx_byte
  import coord_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_strobe,
  output logic       stop_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic             rx_meta, rx_sync, rx_prev;
  rx_state_e        state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [2:0]       bit_idx, bit_idx_d;
  logic [7:0]       shift, shift_d;
  logic             strobe_d, err_d;

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    bit_idx_d = bit_idx;
    shift_d   = shift;
    strobe_d  = 1'b0;
    err_d     = 1'b0;
    unique case (state)
      RX_IDLE: begin
        if (rx_prev && !rx_sync) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (cnt == HALF_BIT) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          // Line back high at mid start bit: a glitch, not a frame.
          state_d   = rx_sync ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt == FULL_BIT) begin
          cnt_d     = '0;
          shift_d   = {rx_sync, shift[7:1]};
          bit_idx_d = bit_idx + 1'b1;
          if (bit_idx == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt == FULL_BIT) begin
          cnt_d = '0;
          if (rx_sync) begin
            strobe_d = 1'b1;
            state_d  = RX_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = RX_BREAK;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      RX_BREAK: begin
        if (rx_sync) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Synchronizer and edge detector reset to the idle (high) line level
      // so reset release cannot fake a start bit.
      rx_meta     <= 1'b1;
      rx_sync     <= 1'b1;
      rx_prev     <= 1'b1;
      state       <= RX_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      byte_strobe <= 1'b0;
      stop_err    <= 1'b0;
    end else begin
      rx_meta     <= rx;
      rx_sync     <= rx_meta;
      rx_prev     <= rx_sync;
      state       <= state_d;
      cnt         <= cnt_d;
      bit_idx     <= bit_idx_d;
      shift       <= shift_d;
      byte_strobe <= strobe_d;
      stop_err    <= err_d;
    end
  end

  assign byte_data = shift;

endmodule

// File: rtl/coord_uart_rx_parser.sv
// Coordinate packet receiver: UART bytes -> checked x/y/z coordinates.
// Packet (MSB first): SYNC, X_HI, X_LO, Y_HI, Y_LO, Z_HI, Z_LO, CSUM,
// where CSUM is the XOR of the six payload bytes.
//   clk, rst_n  : system clock, asynchronous active-low reset
//   uart_rx     : asynchronous serial input, idle high
//   x_coord     : signed pan offset
//   y_coord     : depth, never 0 when coord_valid is high
//   z_coord     : height
//   coord_valid : 1-cycle pulse, x/y/z updated in the same cycle
//   frame_err   : 1-cycle pulse on a framing error, bad packet or timeout
// Optional feature: define COORD_TIMEOUT_EN to abandon a partial packet
// after TIMEOUT_CYCLES clocks without a byte.
`timescale 1ns/1ps
module coord_uart_rx_parser
  import coord_rx_pkg::*;
#(
  parameter int          CLK_FREQ_HZ    = 100_000_000,
  parameter int          BAUD_RATE      = 115_200,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 200_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               uart_rx,
  output logic signed [15:0] x_coord,
  output logic        [15:0] y_coord,
  output logic        [15:0] z_coord,
  output logic               coord_valid,
  output logic               frame_err
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;

  logic [7:0]    byte_data;
  logic          byte_strobe, stop_err;
  parser_state_e state, state_d;
  logic [15:0]   x_sh, y_sh, z_sh;
  logic [7:0]    csum;
  logic          good_pkt, bad_pkt, timeout;

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx          (uart_rx),
    .byte_data   (byte_data),
    .byte_strobe (byte_strobe),
    .stop_err    (stop_err)
  );

  // A SYNC_BYTE value inside the payload is plain data: only S_SYNC looks
  // for the marker.
  always_comb begin
    state_d  = state;
    good_pkt = 1'b0;
    bad_pkt  = 1'b0;
    if (stop_err || timeout) begin
      state_d = S_SYNC;
    end else if (byte_strobe) begin
      unique case (state)
        S_SYNC: if (byte_data == SYNC_BYTE) state_d = S_X_HI;
        S_CSUM: begin
          state_d = S_SYNC;
          if (byte_data == csum && y_sh != 16'd0) good_pkt = 1'b1;
          else                                    bad_pkt  = 1'b1;
        end
        default: state_d = parser_state_e'(state + 3'd1);
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_SYNC;
    else        state <= state_d;
  end

  // Shadow registers and running XOR; the XOR clears on the SYNC byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_sh <= '0;
      y_sh <= '0;
      z_sh <= '0;
      csum <= '0;
    end else if (byte_strobe) begin
      csum <= (state == S_SYNC) ? 8'h00 : (csum ^ byte_data);
      case (state)
        S_X_HI:  x_sh[15:8] <= byte_data;
        S_X_LO:  x_sh[7:0]  <= byte_data;
        S_Y_HI:  y_sh[15:8] <= byte_data;
        S_Y_LO:  y_sh[7:0]  <= byte_data;
        S_Z_HI:  z_sh[15:8] <= byte_data;
        S_Z_LO:  z_sh[7:0]  <= byte_data;
        default: ;
      endcase
    end
  end

  // Outputs load one cycle after the checksum byte, together with the
  // strobe. good_pkt needs a byte_strobe, which excludes stop_err and
  // timeout, so coord_valid and frame_err never coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_coord     <= X_RST;
      y_coord     <= Y_RST;
      z_coord     <= Z_RST;
      coord_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      coord_valid <= good_pkt;
      frame_err   <= bad_pkt | stop_err | timeout;
      if (good_pkt) begin
        x_coord <= x_sh;
        y_coord <= y_sh;
        z_coord <= z_sh;
      end
    end
  end

`ifdef COORD_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                        to_cnt <= '0;
    else if (byte_strobe || timeout || state == S_SYNC) to_cnt <= '0;
    else                                               to_cnt <= to_cnt + 1'b1;
  end

  // A byte arriving on the expiry cycle wins over the timeout.
  assign timeout = (state != S_SYNC) && !byte_strobe && (to_cnt == TO_LAST);
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign timeout        = 1'b0;
`endif

endmodule

// File: tb/tb_coord_uart_rx_parser.sv
// Self-checking bench for coord_uart_rx_parser. Bytes are driven with a
// bit-accurate UART task at 8680 ns per bit; the clock is scaled so one bit
// is 10 clocks. A packet-level model tracks the expected coordinates and
// pulse counts.
`timescale 1ns/1ps
module tb_coord_uart_rx_parser;

  localparam int  CLK_HALF_NS = 434;
  localparam int  BIT_NS      = 8680;
  localparam int  TO_CYCLES   = 2304;  // 2 ms at this clock

  logic        clk = 1'b0;
  logic        rst_n;
  logic        uart_rx;
  logic [15:0] x_coord, y_coord, z_coord;
  logic        coord_valid, frame_err;

  coord_uart_rx_parser #(
    .CLK_FREQ_HZ    (1_152_000),
    .BAUD_RATE      (115_200),
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (TO_CYCLES)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .uart_rx     (uart_rx),
    .x_coord     (x_coord),
    .y_coord     (y_coord),
    .z_coord     (z_coord),
    .coord_valid (coord_valid),
    .frame_err   (frame_err)
  );

  always #(CLK_HALF_NS) clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Observed pulse activity
  int          n_cv = 0;
  int          n_fe = 0;
  logic [47:0] got_q[$];
  logic        prev_strobe = 1'b0;

  // Reference model state
  int          exp_cv = 0;
  int          exp_fe = 0;
  logic [15:0] exp_x = 16'd0, exp_y = 16'd1000, exp_z = 16'd1000;
  logic [47:0] exp_q[$];

  task automatic check(input string tag, input logic [47:0] observed, input logic [47:0] expected);
    n_vec++;
    assert (observed === expected) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Outputs are sampled on the falling edge, away from the updating edge.
  always @(negedge clk) begin
    if (coord_valid) begin
      n_cv++;
      got_q.push_back({x_coord, y_coord, z_coord});
      check("latency", {47'd0, prev_strobe}, 48'd1);
    end
    if (frame_err) n_fe++;
    if (coord_valid || frame_err)
      check("exclusive", {47'd0, coord_valid & frame_err}, 48'd0);
    prev_strobe = dut.u_rx.byte_strobe;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      #(BIT_NS);
    end
    uart_rx = stop_bit;
    #(BIT_NS);
    uart_rx = 1'b1;
    if (!stop_bit) #(BIT_NS);
  endtask

  // bad_stop_idx: byte position sent with a low stop bit, -1 for none
  task automatic send_pkt(input logic [63:0] p, input int bad_stop_idx);
    for (int i = 0; i < 8; i++)
      send_byte(p[63-8*i -: 8], (i != bad_stop_idx));
  endtask

  function automatic logic [63:0] mk_pkt(input logic [15:0] x, input logic [15:0] y,
                                         input logic [15:0] z);
    logic [7:0] cs;
    cs = x[15:8] ^ x[7:0] ^ y[15:8] ^ y[7:0] ^ z[15:8] ^ z[7:0];
    return {8'hA5, x, y, z, cs};
  endfunction

  // Packet-level rule: accepted iff the checksum matches and y is non-zero.
  task automatic model_pkt(input logic [63:0] p);
    logic [7:0] b[8];
    logic [7:0] acc;
    for (int i = 0; i < 8; i++) b[i] = p[63-8*i -: 8];
    acc = 8'h00;
    for (int i = 1; i <= 6; i++) acc ^= b[i];
    if (acc == b[7] && {b[3], b[4]} != 16'd0) begin
      exp_x = {b[1], b[2]};
      exp_y = {b[3], b[4]};
      exp_z = {b[5], b[6]};
      exp_q.push_back({exp_x, exp_y, exp_z});
      exp_cv++;
    end else begin
      exp_fe++;
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_valid_cnt"}, 48'(n_cv), 48'(exp_cv));
    check({tag, "_err_cnt"},   48'(n_fe), 48'(exp_fe));
    check({tag, "_x"}, {32'd0, x_coord}, {32'd0, exp_x});
    check({tag, "_y"}, {32'd0, y_coord}, {32'd0, exp_y});
    check({tag, "_z"}, {32'd0, z_coord}, {32'd0, exp_z});
    while (got_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_captured"}, got_q.pop_front(), exp_q.pop_front());
    check({tag, "_capture_backlog"}, 48'(got_q.size() + exp_q.size()), 48'd0);
  endtask

  localparam logic [63:0] PKT1 = 64'hA5_03E8_03E8_07D0_D7;
  localparam logic [63:0] PKT2 = 64'hA5_FA24_03E8_01F4_C0;

  initial begin
    logic [63:0] pkt;
    logic [15:0] rx_, ry, rz;

    rst_n   = 1'b0;
    uart_rx = 1'b1;
    // Offset keeps stimulus and checks off the clock edges.
    #100;
    #(3 * 2 * CLK_HALF_NS);
    check_state("reset");
    check("reset_valid", {47'd0, coord_valid}, 48'd0);
    check("reset_err",   {47'd0, frame_err},   48'd0);
    rst_n = 1'b1;
    #(BIT_NS);

    // Case 1: nominal packet
    send_pkt(PKT1, -1);
    model_pkt(PKT1);
    #(BIT_NS);
    check_state("case1");
    check("case1_x_const", {32'd0, x_coord}, 48'd1000);
    check("case1_z_const", {32'd0, z_coord}, 48'd2000);

    // Case 2: negative x
    send_pkt(PKT2, -1);
    model_pkt(PKT2);
    #(BIT_NS);
    check_state("case2");
    check("case2_x_const", {32'd0, x_coord}, 48'h00000000FA24);

    // Case 3: bad checksum, outputs hold
    pkt = {PKT1[63:8], 8'hD6};
    send_pkt(pkt, -1);
    model_pkt(pkt);
    #(BIT_NS);
    check_state("case3");

    // Case 4: leading garbage is discarded silently
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h5A, 1'b1);
    send_pkt(PKT1, -1);
    model_pkt(PKT1);
    #(BIT_NS);
    check_state("case4");

    // Case 5a: y == 0 with a correct checksum is rejected
    pkt = mk_pkt(16'h03E8, 16'h0000, 16'h07D0);
    send_pkt(pkt, -1);
    model_pkt(pkt);
    #(BIT_NS);
    check_state("case5a");

    // Case 5b: framing error on X_LO, then resync on the next packet
    send_pkt(pkt, 2);
    exp_fe++;
    #(BIT_NS);
    check_state("case5b");
    send_pkt(PKT2, -1);
    model_pkt(PKT2);
    #(BIT_NS);
    check_state("case5b_resync");

    // Short low glitch is not a start bit
    uart_rx = 1'b0;
    #(4 * CLK_HALF_NS);
    uart_rx = 1'b1;
    #(2 * BIT_NS);
    check_state("glitch");

    // Break: one framing error, then normal reception once the line is high
    uart_rx = 1'b0;
    #(30 * BIT_NS);
    uart_rx = 1'b1;
    #(2 * BIT_NS);
    exp_fe++;
    check_state("break");
    send_pkt(PKT1, -1);
    model_pkt(PKT1);
    #(BIT_NS);
    check_state("after_break");

    // Case 6: reset mid-packet
    send_byte(8'hA5, 1'b1);
    send_byte(8'hFA, 1'b1);
    send_byte(8'h24, 1'b1);
    #(BIT_NS / 2);
    rst_n = 1'b0;
    #(2 * 2 * CLK_HALF_NS);
    exp_x = 16'd0;
    exp_y = 16'd1000;
    exp_z = 16'd1000;
    check_state("case6_reset");
    rst_n = 1'b1;
    #(BIT_NS);
    send_pkt(PKT2, -1);
    model_pkt(PKT2);
    #(BIT_NS);
    check_state("case6_next");

`ifdef COORD_TIMEOUT_EN
    // Timeout: 3 ms gap after Y_HI abandons the packet
    send_byte(8'hA5, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'hE8, 1'b1);
    send_byte(8'h03, 1'b1);
    #(3_000_000);
    exp_fe++;
    check_state("timeout");
    send_pkt(PKT1, -1);
    model_pkt(PKT1);
    #(BIT_NS);
    check_state("timeout_next");
`endif

    // Random packets, sent back-to-back in pairs
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 2; j++) begin
        rx_ = 16'($urandom);
        ry  = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
        rz  = 16'($urandom);
        pkt = mk_pkt(rx_, ry, rz);
        if ($urandom_range(0, 3) == 0) pkt[7:0] = pkt[7:0] ^ (8'd1 << $urandom_range(0, 7));
        send_pkt(pkt, -1);
        model_pkt(pkt);
      end
      #(BIT_NS);
      check_state("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
